seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial pattern detector; generalises the fixed 1010 Moore detectors.
//  Pattern, length (1..PAT_W) and overlap mode are runtime-programmable; in_valid qualifies bits.
//  Emits a registered one-cycle match pulse and a saturating match counter.
//  Sits on the serial bit-stream path; reset config reproduces the 1010 non-overlapping detector.
// PARAMETERS
//  PAT_W    8        max pattern length in bits (>=2)
//  CNT_W    16       match counter width
//  LEN_W    $clog2(PAT_W+1)  pattern-length field width (derived, do not override)
//  RST_PAT  8'h0A    pattern loaded at reset (LSB-aligned)
//  RST_LEN  4        pattern length loaded at reset
//  RST_OVL  1'b0     overlap mode at reset (0 = non-overlapping)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  in_valid     in   1      in_bit is sampled this cycle
//  in_bit       in   1      serial data bit
//  cfg_load     in   1      one-cycle strobe: latch cfg_pat/cfg_len/cfg_ovl
//  cfg_pat      in   PAT_W  pattern; bit [len-1] is first bit received, bit [0] last
//  cfg_len      in   LEN_W  pattern length
//  cfg_ovl      in   1      1 = overlapping, 0 = non-overlapping
//  cnt_clr      in   1      synchronous clear of match_count
//  match        out  1      one-cycle pulse, completed pattern
//  match_count  out  CNT_W  saturating number of matches
//  armed        out  1      fill counter >= active length (next matching bit fires)
// BEHAVIOUR
//  Reset (async): pat<=RST_PAT, len<=RST_LEN, ovl<=RST_OVL, history<=0, fill<=0,
//   match<=0, match_count<=0, armed<=0.
//  State: PAT_W-bit history shift reg (new bit into [0]); fill counter 0..PAT_W (saturating),
//   counting valid bits since reset, cfg_load, or last match (non-overlap mode only).
//  Per cycle with in_valid=1 and cfg_load=0:
//   hist_n = {history[PAT_W-2:0], in_bit}; fill_n = min(fill+1, PAT_W).
//   hit = (len!=0) && (fill_n >= len) && (hist_n[len-1:0] == pat[len-1:0]).
//   hit & ovl=1: history<=hist_n, fill<=fill_n (suffix reusable).
//   hit & ovl=0: fill<=0 (history contents ignored until refilled).
//   no hit: history<=hist_n, fill<=fill_n.
//  in_valid=0: history, fill hold; match<=0.
//  Latency: match asserted in cycle after the edge that sampled the completing bit; 1 cycle wide.
//   Back-to-back hits (overlap, len=1) give match high on consecutive cycles.
//  match_count: +1 per hit, saturates at all-ones, never wraps.
//  cnt_clr: count<=0; if hit in same cycle, clear wins (count=0), match still pulses.
//  cfg_load: latch config, history<=0, fill<=0, match<=0; in_bit that cycle discarded;
//   match_count unaffected. New config applies to bits from next cycle.
//  cfg_len > PAT_W clamped to PAT_W at load; cfg_len = 0 disables detection (no hits).
//  armed: registered, = (fill >= len) && (len != 0), reflects post-update fill.
//  rst mid-pattern: partial history discarded, config reverts to RST_* values.
// TESTING
//  1 After reset, bits 1,0,1,0,1,0,1,0,1,0 (valid every cycle) -> match after bits 4,8; count=2.
//  2 cfg_load pat=4'b1010 len=4 ovl=1, same stream -> match after bits 4,6,8,10; count=4.
//  3 len=1 pat=1 ovl=1, bits 1,1,1 with in_valid gaps -> one pulse per valid 1, none in gaps.
//  4 CNT_W=3, 9 matches -> count saturates at 7; cnt_clr in cycle of a hit -> count 0, match=1.
//  5 cfg_load after bits 1,0,1 then 0 -> no match (history flushed); cfg_len=0 -> never matches.
//  6 rst asserted after 1,0,1 mid-stream -> outputs 0 immediately; next 0 alone gives no match.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-programmable pattern, length and overlap mode.
// It produces a registered one-cycle match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 16,
  parameter int               LEN_W   = $clog2(PAT_W + 1),
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'h0A),
  parameter logic [LEN_W-1:0] RST_LEN = LEN_W'(4),
  parameter logic             RST_OVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic             ovl_r;
  logic [PAT_W-1:0] hist_r;
  logic [LEN_W-1:0] fill_r;

  logic [PAT_W-1:0] hist_n_s;
  logic [LEN_W-1:0] fill_n_s;
  logic [PAT_W-1:0] mask_s;
  logic             hit_s;
  logic [PAT_W-1:0] pat_d_s;
  logic [LEN_W-1:0] len_d_s;
  logic             ovl_d_s;
  logic [PAT_W-1:0] hist_d_s;
  logic [LEN_W-1:0] fill_d_s;
  logic [CNT_W-1:0] count_d_s;
  logic             armed_d_s;

  // Candidate history/fill after this bit and the hit decision against the active pattern.
  always_comb begin
    hist_n_s = {hist_r[PAT_W-2:0], in_bit};
    if (fill_r >= LEN_MAX) begin
      fill_n_s = LEN_MAX;
    end else begin
      fill_n_s = fill_r + LEN_W'(1);
    end
    if (len_r >= LEN_MAX) begin
      mask_s = {PAT_W{1'b1}};
    end else begin
      mask_s = (PAT_W'(1) << len_r) - PAT_W'(1);
    end
    if (in_valid && !cfg_load && (len_r != LEN_W'(0)) && (fill_n_s >= len_r) &&
        ((hist_n_s & mask_s) == (pat_r & mask_s))) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Next-state selection for configuration, history, fill, counter and armed flag.
  always_comb begin
    pat_d_s  = pat_r;
    len_d_s  = len_r;
    ovl_d_s  = ovl_r;
    hist_d_s = hist_r;
    fill_d_s = fill_r;
    if (cfg_load) begin
      pat_d_s  = cfg_pat;
      len_d_s  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      ovl_d_s  = cfg_ovl;
      hist_d_s = {PAT_W{1'b0}};
      fill_d_s = LEN_W'(0);
    end else if (in_valid) begin
      // A non-overlapping hit restarts the fill so no bit of the match is reused.
      if (hit_s && !ovl_r) begin
        fill_d_s = LEN_W'(0);
      end else begin
        hist_d_s = hist_n_s;
        fill_d_s = fill_n_s;
      end
    end else begin
      fill_d_s = fill_r;
    end

    if (cnt_clr) begin
      count_d_s = {CNT_W{1'b0}};
    end else if (hit_s && (match_count != CNT_MAX)) begin
      count_d_s = match_count + CNT_W'(1);
    end else begin
      count_d_s = match_count;
    end

    armed_d_s = (len_d_s != LEN_W'(0)) && (fill_d_s >= len_d_s);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r       <= RST_PAT;
      len_r       <= RST_LEN;
      ovl_r       <= RST_OVL;
      hist_r      <= {PAT_W{1'b0}};
      fill_r      <= LEN_W'(0);
      match       <= 1'b0;
      match_count <= {CNT_W{1'b0}};
      armed       <= 1'b0;
    end else begin
      pat_r       <= pat_d_s;
      len_r       <= len_d_s;
      ovl_r       <= ovl_d_s;
      hist_r      <= hist_d_s;
      fill_r      <= fill_d_s;
      match       <= hit_s;
      match_count <= count_d_s;
      armed       <= armed_d_s;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a vector table plus hand sequences for
// asynchronous reset and counter saturation (via a second, 3-bit-counter instance).
module tb_seq_detector_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_bit, cfg_load, cfg_ovl, cnt_clr;
  logic [7:0]  cfg_pat;
  logic [3:0]  cfg_len;
  logic        match, armed, match2, armed2;
  logic [15:0] match_count;
  logic [2:0]  count2;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        vld, b, ld, clr;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic        e_match;
    logic [15:0] e_count;
    logic        e_armed;
  } vec_t;

  vec_t tbl[$];

  seq_detector_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .match(match), .match_count(match_count), .armed(armed)
  );

  seq_detector_param #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .match(match2), .match_count(count2), .armed(armed2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic b, input logic ld, input logic clr,
                     input logic [7:0] p, input logic [3:0] l, input logic o,
                     input logic em, input logic [15:0] ec, input logic ea);
    vec_t t;
    t.vld = v; t.b = b; t.ld = ld; t.clr = clr; t.pat = p; t.len = l; t.ovl = o;
    t.e_match = em; t.e_count = ec; t.e_armed = ea;
    tbl.push_back(t);
  endtask

  task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                      input logic [7:0] p, input logic [3:0] l, input logic o);
    in_valid = v; in_bit = b; cfg_load = ld; cnt_clr = clr;
    cfg_pat = p; cfg_len = l; cfg_ovl = o;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    step(1'b1, b, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  initial begin
    logic [1:0] s3;
    s3 = 2'b10;
    // Default 1010 non-overlapping stream
    for (int i = 0; i < 10; i++) begin
      add(1'b1, ~i[0], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0,
          (i == 3 || i == 7), (i < 3) ? 16'd0 : (i < 7) ? 16'd1 : 16'd2, 1'b0);
    end
    // Overlapping 1010
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h0A, 4'd4, 1'b1, 1'b0, 16'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      add(1'b1, ~i[0], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0,
          (i >= 3 && i[0]), 16'(2 + ((i >= 3) ? (i - 1) / 2 : 0)), (i >= 3));
    end
    // len=1 pattern '1', overlap, with valid gaps and cnt_clr
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 4'd1, 1'b1, 1'b0, 16'd6, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 16'd7, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 16'd7, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 16'd8, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 16'd8, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 16'd8, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 16'd9, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 16'd10, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 16'd10, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 16'd0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 16'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    // History flush by cfg_load mid-pattern
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h0A, 4'd4, 1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, ~i[0], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h0A, 4'd4, 1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, i[0], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 16'd1, 1'b0);
    // len=0 never matches, even though pattern 0 with empty mask would compare equal
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 16'd1, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 16'd1, 1'b0);
    // cfg_len=15 clamps to 8: full-width pattern A5 must match
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd15, 1'b0, 1'b0, 16'd1, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      s3 = 2'(i);
      add(1'b1, (8'hA5 >> i) & 8'h01 ? 1'b1 : 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0,
          (i == 0), (i == 0) ? 16'd2 : 16'd1, 1'b0);
    end

    rst = 1'b1;
    in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_pat = 8'h00; cfg_len = 4'd0; cfg_ovl = 1'b0;
    #12;
    chk("reset match", {31'd0, match}, 32'd0);
    chk("reset count", {16'd0, match_count}, 32'd0);
    chk("reset armed", {31'd0, armed}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].b, tbl[i].ld, tbl[i].clr, tbl[i].pat, tbl[i].len, tbl[i].ovl);
      chk($sformatf("v%0d match", i), {31'd0, match}, {31'd0, tbl[i].e_match});
      chk($sformatf("v%0d count", i), {16'd0, match_count}, {16'd0, tbl[i].e_count});
      chk($sformatf("v%0d armed", i), {31'd0, armed}, {31'd0, tbl[i].e_armed});
    end

    // Asynchronous reset mid-pattern: count must clear before any clock edge
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    rst = 1'b1;
    #1;
    chk("async rst count", {16'd0, match_count}, 32'd0);
    chk("async rst match", {31'd0, match}, 32'd0);
    chk("async rst armed", {31'd0, armed}, 32'd0);
    #1;
    rst = 1'b0;
    bit_in(1'b0);
    chk("post rst lone 0", {31'd0, match}, 32'd0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    chk("post rst armed", {31'd0, armed}, 32'd1);
    chk("post rst no early", {31'd0, match}, 32'd0);
    bit_in(1'b0);
    chk("post rst default pat", {31'd0, match}, 32'd1);
    chk("post rst count", {16'd0, match_count}, 32'd1);

    // Saturation on the 3-bit counter instance
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1);
    chk("sat pre count", {29'd0, count2}, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      bit_in(1'b1);
      chk($sformatf("sat%0d match", k), {31'd0, match2}, 32'd1);
      chk($sformatf("sat%0d count3", k), {29'd0, count2}, (k > 7) ? 32'd7 : 32'(k));
      chk($sformatf("sat%0d count16", k), {16'd0, match_count}, 32'(k));
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
    chk("clr+hit match", {31'd0, match}, 32'd1);
    chk("clr+hit count", {16'd0, match_count}, 32'd0);
    chk("clr+hit count3", {29'd0, count2}, 32'd0);
    bit_in(1'b1);
    chk("after clr count", {16'd0, match_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
